// File: rtl/mul7_pkg.sv
// Shared widths and output-slot state encoding for the mul7_arb slice.
package mul7_pkg;

    localparam int unsigned MUL7_IN_W  = 6;
    localparam int unsigned MUL7_OUT_W = 10;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/const7_mult.sv
// Combinational constant multiplier: prod_c = 7*x computed as (x<<3)-x.
module const7_mult
    import mul7_pkg::*;
(
    input  logic [MUL7_IN_W-1:0]  x,
    output logic [MUL7_OUT_W-1:0] prod_c
);

    logic [MUL7_OUT_W-1:0] x_ext;

    assign x_ext  = MUL7_OUT_W'(x);
    // 8x - x never underflows and peaks at 441, so the 10-bit result is exact
    assign prod_c = (x_ext << 3) - x_ext;

endmodule

// File: rtl/mul7_arb.sv
// Round-robin arbiter in front of a shared x7 multiplier with a one-entry registered output slot.
// Optional per-requester saturating grant counters: define MUL7_ARB_GRANT_CNT_EN.
module mul7_arb
    import mul7_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             i_req_valid,
    input  logic [MUL7_IN_W*N_REQ-1:0]   i_req_data,
    output logic [N_REQ-1:0]             o_req_ready,
    output logic                         o_valid,
    output logic [MUL7_OUT_W-1:0]        o_data,
    output logic [$clog2(N_REQ)-1:0]     o_tag,
`ifdef MUL7_ARB_GRANT_CNT_EN
    output logic [CNT_W*N_REQ-1:0]       o_grant_cnt,
`endif
    input  logic                         i_ready
);

    localparam int unsigned TAG_W = $clog2(N_REQ);

    state_t                 state;
    state_t                 state_nxt;
    logic [TAG_W-1:0]       ptr;
    logic [TAG_W-1:0]       win_idx;
    logic                   win_found;
    logic                   slot_free;
    logic                   grant;
    logic [MUL7_IN_W-1:0]   mul_in;
    logic [MUL7_OUT_W-1:0]  mul_out;

    assign slot_free = (state == EMPTY) || i_ready;

    // Round-robin search from ptr+1; scanning farthest-first lets the nearest valid win.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned off = N_REQ; off >= 1; off--) begin
            cand = (32'(ptr) + off) % N_REQ;
            if (i_req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = TAG_W'(cand);
            end
        end
    end

    // Reset gating keeps the accept strobe quiet while the slot is being cleared.
    assign grant = win_found && slot_free && rst_n;

    always_comb begin
        o_req_ready = '0;
        if (grant) begin
            o_req_ready[win_idx] = 1'b1;
        end
    end

    assign mul_in = i_req_data[32'(win_idx)*MUL7_IN_W +: MUL7_IN_W];

    const7_mult u_mult (
        .x      (mul_in),
        .prod_c (mul_out)
    );

    // Output slot FSM: a grant always refills the slot, even while it drains.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (grant) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (grant) begin
                    state_nxt = FULL;
                end else if (i_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    assign o_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data <= '0;
            o_tag  <= '0;
            ptr    <= TAG_W'(N_REQ - 1);
        end else if (grant) begin
            o_data <= mul_out;
            o_tag  <= win_idx;
            ptr    <= win_idx;
        end
    end

`ifdef MUL7_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] grant_cnt [N_REQ];

    // Saturating per-requester grant counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                grant_cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (grant && (win_idx == TAG_W'(k)) && (grant_cnt[k] != '1)) begin
                    grant_cnt[k] <= grant_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        o_grant_cnt = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            o_grant_cnt[k*CNT_W +: CNT_W] = grant_cnt[k];
        end
    end
`endif

endmodule

// File: tb/tb_mul7_arb.sv
// Self-checking bench for mul7_arb: directed table, corner sequences, sweep and random vs. a behavioural model.
module tb_mul7_arb;

    localparam int NR   = 4;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [23:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [9:0]  out_data;
    logic [1:0]  out_tag;
    logic        rdy;
`ifdef MUL7_ARB_GRANT_CNT_EN
    logic [7:0]  grant_cnt;
`endif

    mul7_arb #(.N_REQ(NR), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_tag       (out_tag),
`ifdef MUL7_ARB_GRANT_CNT_EN
        .o_grant_cnt (grant_cnt),
`endif
        .i_ready     (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    int m_valid;
    int m_data;
    int m_tag;
    int m_ptr;
    int m_cnt [NR];
    int cur_win;
    int cur_x;
    logic cur_rdy;

    typedef struct {
        logic [3:0]  v;
        logic [23:0] d;
        logic        r;
        logic [3:0]  er;
        logic        ev;
        logic [9:0]  ed;
        logic [1:0]  et;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_winner(input logic [3:0] v, input logic r);
        if (m_valid != 0 && !r) return -1;
        for (int off = 1; off <= NR; off++) begin
            int k;
            k = (m_ptr + off) % NR;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_data  = 0;
        m_tag   = 0;
        m_ptr   = NR - 1;
        for (int k = 0; k < NR; k++) m_cnt[k] = 0;
    endtask

    // Apply inputs at posedge+1, compare at the following negedge.
    task automatic drive(input logic [3:0] v, input logic [23:0] d, input logic r);
        logic [3:0] exp_rdy;
        req_valid = v;
        req_data  = d;
        rdy       = r;
        cur_rdy   = r;
        #4;
        check("o_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid != 0) begin
            check("o_data", 32'(out_data), 32'(m_data));
            check("o_tag", 32'(out_tag), 32'(m_tag));
        end
        cur_win = model_winner(v, r);
        exp_rdy = (cur_win >= 0) ? 4'(1 << cur_win) : 4'd0;
        check("o_req_ready", 32'(req_ready), 32'(exp_rdy));
        cur_x = (cur_win >= 0) ? int'((d >> (6 * cur_win)) & 24'h3F) : 0;
`ifdef MUL7_ARB_GRANT_CNT_EN
        for (int k = 0; k < NR; k++) begin
            logic [7:0] gc;
            gc = grant_cnt;
            check("grant_cnt", 32'((gc >> (k * CW)) & 8'h3), 32'(m_cnt[k]));
        end
`endif
    endtask

    task automatic advance();
        if (cur_win >= 0) begin
            m_valid = 1;
            m_data  = 7 * cur_x;
            m_tag   = cur_win;
            m_ptr   = cur_win;
            if (m_cnt[cur_win] < CMAX) m_cnt[cur_win]++;
        end else if (cur_rdy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously with requests pending, then release on the next edge.
    task automatic do_reset();
        req_valid = 4'hF;
        req_data  = 24'hFFFFFF;
        rdy       = 1'b1;
        rst_n     = 1'b0;
        #1;
        check("rst o_valid", 32'(out_valid), 32'd0);
        check("rst o_data", 32'(out_data), 32'd0);
        check("rst o_tag", 32'(out_tag), 32'd0);
        check("rst o_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rdy       = 1'b0;
        model_reset();

        // Single request then fairness across four continuous requesters.
        tbl[0] = '{4'b0001, {18'd0, 6'd5},             1'b1, 4'b0001, 1'b0, 10'd0,  2'd0};
        tbl[1] = '{4'b1111, {6'd4, 6'd3, 6'd2, 6'd1},  1'b1, 4'b0010, 1'b1, 10'd35, 2'd0};
        tbl[2] = '{4'b1111, {6'd4, 6'd3, 6'd2, 6'd1},  1'b1, 4'b0100, 1'b1, 10'd14, 2'd1};
        tbl[3] = '{4'b1111, {6'd4, 6'd3, 6'd2, 6'd1},  1'b1, 4'b1000, 1'b1, 10'd21, 2'd2};
        tbl[4] = '{4'b1111, {6'd4, 6'd3, 6'd2, 6'd1},  1'b1, 4'b0001, 1'b1, 10'd28, 2'd3};
        tbl[5] = '{4'b0000, 24'd0,                     1'b1, 4'b0000, 1'b1, 10'd7,  2'd0};
        tbl[6] = '{4'b0000, 24'd0,                     1'b1, 4'b0000, 1'b0, 10'd0,  2'd0};

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r);
            check("tbl ready", 32'(req_ready), 32'(tbl[i].er));
            check("tbl valid", 32'(out_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                check("tbl data", 32'(out_data), 32'(tbl[i].ed));
                check("tbl tag", 32'(out_tag), 32'(tbl[i].et));
            end
            advance();
        end

        // Backpressure: 441 held for three stalled cycles, then drained and refilled in one cycle.
        do_reset();
        drive(4'b0001, {18'd0, 6'd63}, 1'b1);
        check("bp first grant", 32'(req_ready), 32'h1);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(4'b1110, {6'd9, 6'd8, 6'd7, 6'd0}, 1'b0);
            check("bp stall ready", 32'(req_ready), 32'd0);
            check("bp hold data", 32'(out_data), 32'd441);
            check("bp hold valid", 32'(out_valid), 32'd1);
            advance();
        end
        drive(4'b1110, {6'd9, 6'd8, 6'd7, 6'd0}, 1'b1);
        check("bp release ready", 32'(req_ready), 32'h2);
        advance();
        check("bp next data", 32'(out_data), 32'd49);
        check("bp next tag", 32'(out_tag), 32'd1);
        drive(4'b0000, 24'd0, 1'b1);
        advance();

        // Reset while a result is pending: it must vanish and requester 0 wins first after.
        drive(4'b0100, {6'd0, 6'd11, 6'd0, 6'd0}, 1'b1);
        advance();
        drive(4'b0000, 24'd0, 1'b0);
        do_reset();
        check("post rst valid", 32'(out_valid), 32'd0);
        drive(4'b1111, {6'd1, 6'd2, 6'd3, 6'd4}, 1'b1);
        check("post rst winner", 32'(req_ready), 32'h1);
        advance();

        // Exhaustive operand sweep through requester 2 with noise on the others.
        do_reset();
        for (int x = 0; x < 64; x++) begin
            drive(4'b0100, {6'(x + 3), 6'(x), 6'(63 - x), 6'(x * 5)}, 1'b1);
            advance();
            check("sweep data", 32'(out_data), 32'(7 * x));
            check("sweep tag", 32'(out_tag), 32'd2);
            check("sweep msb", 32'(out_data[9]), 32'd0);
        end
        drive(4'b0000, 24'd0, 1'b1);
        advance();

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom), 24'($urandom), ($urandom_range(0, 3) != 0));
            advance();
        end

`ifdef MUL7_ARB_GRANT_CNT_EN
        // Five grants to requester 1 saturate its 2-bit counter at 3.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'b0010, {6'd0, 6'd0, 6'(i), 6'd0}, 1'b1);
            advance();
        end
        drive(4'b0000, 24'd0, 1'b1);
        check("cnt saturate", 32'(grant_cnt), 32'h0C);
        advance();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
